// File: rtl/wash_cycle_timer.sv
// wash_cycle_timer
// Prescales CLK into a one-second tick and counts down a per-phase
// duration selected by TIMER_SEL. It reports the remaining seconds and
// the busy status, and sets TIMER_DONE when the count completes.
// Optional feature: define WM_TIMER_DOOR_PAUSE_EN to freeze counting
// while DOOR_SENSOR is low (door open). PAUSED then reports the freeze.
// All outputs are registered. RST is asynchronous and active-low.
module wash_cycle_timer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int CNT_W       = 16,
  parameter int SHORT_S     = 60,
  parameter int WASH_MED_S  = 1200,
  parameter int WASH_HIGH_S = 1800,
  parameter int SPIN_S      = 300
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TIMER_EN,
  input  logic             SPIN_EN,
  input  logic [1:0]       TIMER_SEL,
  input  logic             DOOR_SENSOR,
  output logic             TIMER_DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] REMAIN,
  output logic             PAUSED
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] D_SHORT  = CNT_W'(SHORT_S);
  localparam logic [CNT_W-1:0] D_MED    = CNT_W'(WASH_MED_S);
  localparam logic [CNT_W-1:0] D_HIGH   = CNT_W'(WASH_HIGH_S);
  localparam logic [CNT_W-1:0] D_SPIN   = CNT_W'(SPIN_S);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_remain;
  logic             r_done;
  logic             r_busy;
  logic             r_paused;

  logic             w_run;
  logic             w_tick;
  logic             w_hold;
  logic [CNT_W-1:0] w_dur;

  assign w_run  = TIMER_EN | SPIN_EN;
  assign w_tick = (r_presc == PRE_LAST);

`ifdef WM_TIMER_DOOR_PAUSE_EN
  // An open door freezes both the prescaler and the seconds count.
  assign w_hold = ~DOOR_SENSOR;
`else
  // The door does not affect counting in this build.
  logic w_unused_door;
  assign w_unused_door = DOOR_SENSOR;
  assign w_hold        = 1'b0;
`endif

  // Select the phase duration. It is only used on the start edge.
  always_comb begin
    w_dur = D_SHORT;
    case (TIMER_SEL)
      2'b00: w_dur = D_SHORT;
      2'b01: w_dur = D_MED;
      2'b10: w_dur = D_HIGH;
      2'b11: w_dur = D_SPIN;
      default: w_dur = D_SHORT;
    endcase
  end

  // Control FSM with the prescaler, the seconds counter and the registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_remain <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_paused <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_run) begin
            r_presc  <= '0;
            r_remain <= w_dur;
            r_paused <= 1'b0;
            // A zero duration completes without ever showing busy.
            if (w_dur == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Dropping run has priority over everything, including the final tick.
          if (!w_run) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_remain <= '0;
            r_presc  <= '0;
            r_paused <= 1'b0;
          end else if (w_hold) begin
            r_paused <= 1'b1;
          end else begin
            r_paused <= 1'b0;
            if (w_tick) begin
              r_presc <= '0;
              // Stop at zero instead of wrapping. The last second completes the phase.
              if (r_remain <= CNT_W'(1)) begin
                r_remain <= '0;
                r_state  <= S_DONE;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
              end else begin
                r_remain <= r_remain - CNT_W'(1);
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
        end
        S_DONE: begin
          // Hold completion until the controller drops run.
          if (!w_run) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_presc  <= '0;
          r_remain <= '0;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_paused <= 1'b0;
        end
      endcase
    end
  end

  assign TIMER_DONE = r_done;
  assign BUSY       = r_busy;
  assign REMAIN     = r_remain;
  assign PAUSED     = r_paused;

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Testbench for wash_cycle_timer. Random and directed stimulus is checked
// against a model that counts total remaining clock cycles.
module tb_wash_cycle_timer;

  localparam int TD = 4;
`ifdef WM_TIMER_DOOR_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        TIMER_EN, SPIN_EN, DOOR_SENSOR;
  logic [1:0]  TIMER_SEL;
  logic        TIMER_DONE, BUSY, PAUSED;
  logic [15:0] REMAIN;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0 = idle, 1 = counting, 2 = done; m_left counts clock cycles to completion.
  int m_mode   = 0;
  int m_left   = 0;
  bit m_paused = 1'b0;

  wash_cycle_timer #(
    .TICK_DIV(TD), .CNT_W(16), .SHORT_S(0), .WASH_MED_S(3), .WASH_HIGH_S(5), .SPIN_S(2)
  ) dut (
    .CLK(CLK), .RST(RST), .TIMER_EN(TIMER_EN), .SPIN_EN(SPIN_EN), .TIMER_SEL(TIMER_SEL),
    .DOOR_SENSOR(DOOR_SENSOR), .TIMER_DONE(TIMER_DONE), .BUSY(BUSY), .REMAIN(REMAIN),
    .PAUSED(PAUSED)
  );

  always #5 CLK = ~CLK;

  function automatic int dur(input logic [1:0] s);
    case (s)
      2'd0: return 0;
      2'd1: return 3;
      2'd2: return 5;
      default: return 2;
    endcase
  endfunction

  function automatic logic [18:0] exp_vec();
    int rem;
    rem = (m_mode == 1) ? (m_left + TD - 1) / TD : 0;
    return {m_mode == 2, m_mode == 1, m_paused, 16'(rem)};
  endfunction

  function automatic logic [18:0] got_vec();
    return {TIMER_DONE, BUSY, PAUSED, REMAIN};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_paused = 1'b0;
  endtask

  // Advance one clock edge. Update the model with the inputs sampled at that edge, then settle.
  task automatic step();
    bit run;
    @(posedge CLK);
    run = TIMER_EN | SPIN_EN;
    case (m_mode)
      0: if (run) begin
        m_paused = 1'b0;
        if (dur(TIMER_SEL) == 0) m_mode = 2;
        else begin m_mode = 1; m_left = dur(TIMER_SEL) * TD; end
      end
      1: if (!run) begin
        m_mode = 0; m_left = 0; m_paused = 1'b0;
      end else if (PAUSE_EN && !DOOR_SENSOR) begin
        m_paused = 1'b1;
      end else begin
        m_paused = 1'b0;
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
      default: if (!run) m_mode = 0;
    endcase
    #1;
  endtask

  task automatic go_idle();
    TIMER_EN = 0; SPIN_EN = 0; DOOR_SENSOR = 1;
    step(); step();
  endtask

  task automatic test_reset();
    RST = 0; TIMER_EN = 0; SPIN_EN = 0; TIMER_SEL = 0; DOOR_SENSOR = 1;
    model_reset();
    #12;
    checks++;
    if (got_vec() !== 19'd0) begin
      failures++; $display("FAIL reset_state got=%h exp=0", got_vec());
    end
    RST = 1;
    step();
    checks++;
    if (got_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_med_done();
    int n;
    TIMER_SEL = 2'b01; TIMER_EN = 1;
    step();
    checks++;
    if (got_vec() !== exp_vec() || REMAIN !== 16'd3 || BUSY !== 1'b1) begin
      failures++; $display("FAIL med_start got=%h exp=%h", got_vec(), exp_vec());
    end
    n = 0;
    while (TIMER_DONE !== 1'b1 && n < 40) begin
      step(); n++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++; $display("FAIL med_count n=%0d got=%h exp=%h", n, got_vec(), exp_vec());
      end
    end
    checks++;
    if (n != 12) begin failures++; $display("FAIL med_latency got=%0d exp=12", n); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (got_vec() !== exp_vec() || TIMER_DONE !== 1'b1) begin
        failures++; $display("FAIL med_hold got=%h exp=%h", got_vec(), exp_vec());
      end
    end
    TIMER_EN = 0;
    step();
    checks++;
    if (got_vec() !== exp_vec() || TIMER_DONE !== 1'b0) begin
      failures++; $display("FAIL med_release got=%h exp=%h", got_vec(), exp_vec());
    end
    go_idle();
  endtask

  task automatic test_spin_sel_change();
    int n;
    TIMER_SEL = 2'b11; SPIN_EN = 1;
    step();
    n = 0;
    while (TIMER_DONE !== 1'b1 && n < 40) begin
      if (n == 2) TIMER_SEL = 2'b10;
      step(); n++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++; $display("FAIL spin_count n=%0d got=%h exp=%h", n, got_vec(), exp_vec());
      end
    end
    checks++;
    if (n != 8) begin failures++; $display("FAIL spin_latency got=%0d exp=8", n); end
    go_idle();
  endtask

  task automatic test_zero_dur();
    TIMER_SEL = 2'b00; TIMER_EN = 1;
    step();
    checks++;
    if (got_vec() !== exp_vec() || TIMER_DONE !== 1'b1 || BUSY !== 1'b0) begin
      failures++; $display("FAIL zero_dur got=%h exp=%h", got_vec(), exp_vec());
    end
    step();
    checks++;
    if (BUSY !== 1'b0 || TIMER_DONE !== 1'b1) begin
      failures++; $display("FAIL zero_hold busy=%b done=%b exp busy=0 done=1", BUSY, TIMER_DONE);
    end
    go_idle();
  endtask

  task automatic test_abort_restart();
    int n;
    TIMER_SEL = 2'b10; TIMER_EN = 1;
    for (int i = 0; i < 6; i++) step();
    TIMER_EN = 0;
    step();
    checks++;
    if (got_vec() !== exp_vec() || got_vec() !== 19'd0) begin
      failures++; $display("FAIL abort got=%h exp=%h", got_vec(), exp_vec());
    end
    TIMER_EN = 1;
    step();
    n = 0;
    while (TIMER_DONE !== 1'b1 && n < 60) begin
      step(); n++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++; $display("FAIL restart n=%0d got=%h exp=%h", n, got_vec(), exp_vec());
      end
    end
    checks++;
    if (n != 20) begin failures++; $display("FAIL restart_latency got=%0d exp=20", n); end
    go_idle();
  endtask

  task automatic test_final_tick_abort();
    TIMER_SEL = 2'b11; TIMER_EN = 1;
    step();
    for (int i = 0; i < 7; i++) step();
    TIMER_EN = 0;
    step();
    checks++;
    if (got_vec() !== exp_vec() || TIMER_DONE !== 1'b0 || BUSY !== 1'b0) begin
      failures++; $display("FAIL final_tick_abort got=%h exp=%h", got_vec(), exp_vec());
    end
    step();
    checks++;
    if (TIMER_DONE !== 1'b0) begin
      failures++; $display("FAIL final_tick_nodone got=%b exp=0", TIMER_DONE);
    end
  endtask

  task automatic test_async_reset();
    TIMER_SEL = 2'b10; TIMER_EN = 1;
    for (int i = 0; i < 5; i++) step();
    RST = 0;
    #2;
    model_reset();
    checks++;
    if (got_vec() !== 19'd0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", got_vec());
    end
    TIMER_EN = 0;
    #2 RST = 1;
    step();
    checks++;
    if (got_vec() !== exp_vec()) begin
      failures++; $display("FAIL post_reset got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_door_pause();
    int n;
    int exp_n;
    DOOR_SENSOR = 1; TIMER_SEL = 2'b01; TIMER_EN = 1;
    step();
    n = 0;
    while (TIMER_DONE !== 1'b1 && n < 60) begin
      DOOR_SENSOR = (n >= 5 && n < 12) ? 1'b0 : 1'b1;
      step(); n++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++; $display("FAIL door n=%0d got=%h exp=%h", n, got_vec(), exp_vec());
      end
    end
    exp_n = PAUSE_EN ? 19 : 12;
    checks++;
    if (n != exp_n) begin failures++; $display("FAIL door_latency got=%0d exp=%0d", n, exp_n); end
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) TIMER_EN = ~TIMER_EN;
      if ($urandom_range(0, 19) == 0) SPIN_EN = ~SPIN_EN;
      TIMER_SEL   = 2'($urandom_range(0, 3));
      DOOR_SENSOR = ($urandom_range(0, 6) != 0);
      step();
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++; $display("FAIL random i=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_med_done();
    test_spin_sel_change();
    test_zero_dur();
    test_abort_restart();
    test_final_tick_abort();
    test_async_reset();
    test_door_pause();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
